// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared state/gate types and fixed-point helpers for the LSTM cell
package lstm_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_MAC, ST_ACT, ST_UPD, ST_OUT} state_e;
    typedef enum logic [1:0] {GATE_I, GATE_F, GATE_G, GATE_O} gate_e;

    function automatic longint sat_fn(input longint x, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) << (dw - 1)) - 1;
        lo = -(longint'(1) << (dw - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // x/4 + 0.5 with floor division, clamped to [0, 1.0]
    function automatic longint hsig_fn(input longint x, input int frac);
        longint one;
        longint y;
        one = longint'(1) << frac;
        y   = (x >>> 2) + (one >>> 1);
        if (y < 0) return 0;
        if (y > one) return one;
        return y;
    endfunction

    function automatic longint htanh_fn(input longint x, input int frac);
        longint one;
        one = longint'(1) << frac;
        if (x > one) return one;
        if (x < -one) return -one;
        return x;
    endfunction

endpackage

// File: rtl/lstm_act.sv
// rtl/lstm_act.sv - saturate a wide value to DW and apply the selected gate activation
module lstm_act
    import lstm_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 4,
    parameter int AW   = 21
) (
    input  logic signed [AW-1:0] x_i,
    input  gate_e                gate_i,
    output logic signed [DW-1:0] y_sat_o,
    output logic signed [DW-1:0] y_act_o
);

    longint s;

    always_comb begin
        s       = sat_fn(longint'(x_i), DW);
        y_sat_o = DW'(s);
        if (gate_i == GATE_G) y_act_o = DW'(htanh_fn(s, FRAC));
        else                  y_act_o = DW'(hsig_fn(s, FRAC));
    end

endmodule

// File: rtl/lstm_seq_cell.sv
// rtl/lstm_seq_cell.sv - sequential single-MAC LSTM cell; LSTM_SAT_FLAG_EN adds sticky sat_o
module lstm_seq_cell
    import lstm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int X_LEN = 8,
    parameter int H_LEN = 8
) (
    input  logic                                         CLOCK_50,
    input  logic                                         reset_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic                                         seq_start,
    input  logic [X_LEN*DW-1:0]                          xt,
    output logic [$clog2(H_LEN*4*(X_LEN+H_LEN+1))-1:0]   w_addr,
    input  logic [DW-1:0]                                w_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [H_LEN*DW-1:0]                          ht,
    output logic [H_LEN*DW-1:0]                          ct
`ifdef LSTM_SAT_FLAG_EN
    ,
    output logic                                         sat_o
`endif
);

    localparam int K   = X_LEN + H_LEN + 1;
    localparam int NWA = $clog2(H_LEN * 4 * K);
    localparam int AW  = 2 * DW + $clog2(K);
    localparam int UW  = (H_LEN > 1) ? $clog2(H_LEN) : 1;
    localparam int TW  = $clog2(K + 1);
    localparam int XW  = X_LEN * DW;
    localparam int HW  = H_LEN * DW;
    localparam logic signed [DW-1:0] ONE = DW'(1 << FRAC);

    state_e                state_q, state_d;
    gate_e                 gate_q, gate_d;
    logic [UW-1:0]         unit_q, unit_d;
    logic [TW-1:0]         t_q, t_d;
    logic [1:0]            ph_q, ph_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [XW-1:0]         x_q, x_d;
    logic [HW-1:0]         hp_q, hp_d, cp_q, cp_d, hn_q, hn_d, cn_q, cn_d;
    logic [HW-1:0]         ht_q, ht_d, ct_q, ct_d;
    logic signed [DW-1:0]  gi_q, gi_d, gf_q, gf_d, gg_q, gg_d, go_q, go_d;
    logic signed [DW-1:0]  c_cur_q, c_cur_d, tc_q, tc_d;

    int                    idx;
    logic signed [DW-1:0]  op, cp_j, act_sat, act_y;
    logic signed [2*DW-1:0] prod, fc_prod, ig_prod, oh_prod;
    logic signed [AW-1:0]  term, c_sum, h_sum, act_x;
    gate_e                 act_gate;
    logic                  last_unit;

    function automatic logic [HW-1:0] put_elem(input logic [HW-1:0] v, input logic [UW-1:0] j,
                                               input logic [DW-1:0] e);
        int sh;
        sh = int'(j) * DW;
        return (v & ~(HW'({DW{1'b1}}) << sh)) | (HW'(e) << sh);
    endfunction

    // Term t arrives on w_data one cycle after its address, so the operand lags by one
    always_comb begin
        idx = int'(t_q) - 1;
        op  = ONE;
        if (idx >= 0 && idx < X_LEN)
            op = DW'(x_q >> (idx * DW));
        else if (idx >= X_LEN && idx < X_LEN + H_LEN)
            op = DW'(hp_q >> ((idx - X_LEN) * DW));
        prod    = $signed(w_data) * op;
        term    = AW'(prod) >>> FRAC;
        cp_j    = DW'(cp_q >> (int'(unit_q) * DW));
        fc_prod = gf_q * cp_j;
        ig_prod = gi_q * gg_q;
        c_sum   = (AW'(fc_prod) >>> FRAC) + (AW'(ig_prod) >>> FRAC);
        oh_prod = go_q * tc_q;
        h_sum   = AW'(oh_prod) >>> FRAC;
    end

    // UPD reuses the activation block: phase 0 saturates c (and yields tanh(c)), phase 1 saturates h
    always_comb begin
        act_x    = acc_q;
        act_gate = gate_q;
        if (state_q == ST_UPD) begin
            act_gate = GATE_G;
            act_x    = (ph_q == 2'd0) ? c_sum : h_sum;
        end
    end

    lstm_act #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_act (
        .x_i     (act_x),
        .gate_i  (act_gate),
        .y_sat_o (act_sat),
        .y_act_o (act_y)
    );

    assign last_unit = (unit_q == UW'(H_LEN - 1));

    always_comb begin
        state_d = state_q;  gate_d = gate_q;  unit_d = unit_q;  t_d = t_q;  ph_d = ph_q;
        acc_d   = acc_q;    x_d    = x_q;     hp_d   = hp_q;    cp_d = cp_q;
        hn_d    = hn_q;     cn_d   = cn_q;    ht_d   = ht_q;    ct_d = ct_q;
        gi_d    = gi_q;     gf_d   = gf_q;    gg_d   = gg_q;    go_d = go_q;
        c_cur_d = c_cur_q;  tc_d   = tc_q;
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        w_addr    = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d    = xt;
                    unit_d = '0;
                    gate_d = GATE_I;
                    t_d    = '0;
                    acc_d  = '0;
                    if (seq_start) begin
                        hp_d = '0;
                        cp_d = '0;
                    end
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (t_q < TW'(K))
                    w_addr = NWA'((int'(unit_q) * 4 + int'(gate_q)) * K + int'(t_q));
                if (t_q != '0) acc_d = acc_q + term;
                if (t_q == TW'(K)) state_d = ST_ACT;
                else               t_d = t_q + 1'b1;
            end
            ST_ACT: begin
                t_d   = '0;
                acc_d = '0;
                case (gate_q)
                    GATE_I:  gi_d = act_y;
                    GATE_F:  gf_d = act_y;
                    GATE_G:  gg_d = act_y;
                    default: go_d = act_y;
                endcase
                if (gate_q == GATE_O) begin
                    ph_d    = 2'd0;
                    state_d = ST_UPD;
                end else begin
                    gate_d  = gate_e'(gate_q + 2'd1);
                    state_d = ST_MAC;
                end
            end
            ST_UPD: begin
                case (ph_q)
                    2'd0: begin
                        c_cur_d = act_sat;
                        tc_d    = act_y;
                        ph_d    = 2'd1;
                    end
                    2'd1: begin
                        hn_d   = put_elem(hn_q, unit_q, act_sat);
                        cn_d   = put_elem(cn_q, unit_q, c_cur_q);
                        gate_d = GATE_I;
                        if (last_unit) begin
                            ph_d = 2'd2;
                        end else begin
                            unit_d  = unit_q + 1'b1;
                            state_d = ST_MAC;
                        end
                    end
                    default: begin
                        hp_d    = hn_q;
                        cp_d    = cn_q;
                        ht_d    = hn_q;
                        ct_d    = cn_q;
                        state_d = ST_OUT;
                    end
                endcase
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;  gate_q <= GATE_I;  unit_q <= '0;  t_q <= '0;  ph_q <= '0;
            acc_q   <= '0;       x_q    <= '0;      hp_q   <= '0;  cp_q <= '0;
            hn_q    <= '0;       cn_q   <= '0;      ht_q   <= '0;  ct_q <= '0;
            gi_q    <= '0;       gf_q   <= '0;      gg_q   <= '0;  go_q <= '0;
            c_cur_q <= '0;       tc_q   <= '0;
        end else begin
            state_q <= state_d;  gate_q <= gate_d;  unit_q <= unit_d;  t_q <= t_d;  ph_q <= ph_d;
            acc_q   <= acc_d;    x_q    <= x_d;     hp_q   <= hp_d;    cp_q <= cp_d;
            hn_q    <= hn_d;     cn_q   <= cn_d;    ht_q   <= ht_d;    ct_q <= ct_d;
            gi_q    <= gi_d;     gf_q   <= gf_d;    gg_q   <= gg_d;    go_q <= go_d;
            c_cur_q <= c_cur_d;  tc_q   <= tc_d;
        end
    end

    assign ht = ht_q;
    assign ct = ct_q;

`ifdef LSTM_SAT_FLAG_EN
    logic sat_q, sat_d, sat_hit;

    // A saturation happened whenever the activation input differs from its clamped value
    always_comb begin
        sat_hit = ((state_q == ST_ACT) || (state_q == ST_UPD && ph_q != 2'd2))
                  && (act_x != AW'(act_sat));
        sat_d = sat_q;
        if (state_q == ST_IDLE && in_valid) sat_d = 1'b0;
        else if (sat_hit)                   sat_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) sat_q <= 1'b0;
        else          sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`endif

endmodule

// File: tb/tb_lstm_seq_cell.sv
// tb/tb_lstm_seq_cell.sv - randomized self-checking bench for lstm_seq_cell against a behavioural model
module tb_lstm_seq_cell;

    localparam int DW    = 8;
    localparam int FRAC  = 4;
    localparam int X_LEN = 8;
    localparam int H_LEN = 8;
    localparam int K     = X_LEN + H_LEN + 1;
    localparam int NW    = H_LEN * 4 * K;
    localparam int NWA   = $clog2(NW);
    localparam int XW    = X_LEN * DW;
    localparam int HW    = H_LEN * DW;
    localparam int LAT   = H_LEN * (4 * (K + 2) + 2) + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid, in_ready, seq_start;
    logic [XW-1:0]   xt;
    logic [NWA-1:0]  w_addr;
    logic [DW-1:0]   w_data;
    logic            out_valid, out_ready;
    logic [HW-1:0]   ht, ct;
`ifdef LSTM_SAT_FLAG_EN
    logic            sat_o;
`endif

    lstm_seq_cell #(.DW(DW), .FRAC(FRAC), .X_LEN(X_LEN), .H_LEN(H_LEN)) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seq_start (seq_start),
        .xt        (xt),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ht        (ht),
        .ct        (ct)
`ifdef LSTM_SAT_FLAG_EN
        ,
        .sat_o     (sat_o)
`endif
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [NW];
    always @(posedge clk) w_data <= mem[w_addr];

    int total = 0;
    int bad   = 0;
    int m_h [H_LEN];
    int m_c [H_LEN];
    int x_arr [X_LEN];
    logic [HW-1:0] rep10;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int f_sat(input int v);
        int hi = (1 << (DW - 1)) - 1;
        int lo = -(1 << (DW - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int f_hsig(input int v);
        int one = 1 << FRAC;
        int y = (v >>> 2) + one / 2;
        return (y < 0) ? 0 : (y > one) ? one : y;
    endfunction

    function automatic int f_htanh(input int v);
        int one = 1 << FRAC;
        return (v > one) ? one : (v < -one) ? -one : v;
    endfunction

    function automatic logic [HW-1:0] pack_h(input int a [H_LEN]);
        logic [HW-1:0] r = '0;
        for (int i = 0; i < H_LEN; i++) r |= HW'($unsigned(DW'(a[i]))) << (i * DW);
        return r;
    endfunction

    function automatic logic [XW-1:0] pack_x(input int a [X_LEN]);
        logic [XW-1:0] r = '0;
        for (int i = 0; i < X_LEN; i++) r |= XW'($unsigned(DW'(a[i]))) << (i * DW);
        return r;
    endfunction

    task automatic model_step(input bit seq);
        int hn [H_LEN];
        int cn [H_LEN];
        int gv [4];
        if (seq) for (int j = 0; j < H_LEN; j++) begin m_h[j] = 0; m_c[j] = 0; end
        for (int j = 0; j < H_LEN; j++) begin
            for (int k = 0; k < 4; k++) begin
                int acc = 0;
                for (int t = 0; t < K; t++) begin
                    int op = (t < X_LEN) ? x_arr[t] : (t < X_LEN + H_LEN) ? m_h[t - X_LEN] : (1 << FRAC);
                    int w  = int'(mem[(j * 4 + k) * K + t]);
                    acc += (w * op) >>> FRAC;
                end
                gv[k] = (k == 2) ? f_htanh(f_sat(acc)) : f_hsig(f_sat(acc));
            end
            cn[j] = f_sat(((gv[1] * m_c[j]) >>> FRAC) + ((gv[0] * gv[2]) >>> FRAC));
            hn[j] = f_sat((gv[3] * f_htanh(cn[j])) >>> FRAC);
        end
        m_h = hn;
        m_c = cn;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < NW; a++) mem[a] = '0;
    endtask

    task automatic set_bias(input int k, input int v);
        for (int j = 0; j < H_LEN; j++) mem[(j * 4 + k) * K + K - 1] = DW'(v);
    endtask

    task automatic start_step(input bit seq);
        xt        = pack_x(x_arr);
        in_valid  = 1'b1;
        seq_start = seq;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        seq_start = 1'b0;
    endtask

    task automatic finish_step(input string tag);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_ht"}, ht, pack_h(m_h));
        check({tag, "_ct"}, ct, pack_h(m_c));
    endtask

    task automatic do_step(input string tag, input bit seq);
        model_step(seq);
        start_step(seq);
        check({tag, "_busy"}, in_ready, 1'b0);
        finish_step(tag);
    endtask

    task automatic out_ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic set_037();
        clear_mem();
        set_bias(0, 8'h7F);
        set_bias(1, 8'h80);
        set_bias(2, 8'h10);
        set_bias(3, 8'h7F);
    endtask

    initial begin
        int changes;
        int busy_err;
        logic [HW-1:0] ht_s, ct_s;
        rep10     = {H_LEN{8'h10}};
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        seq_start = 1'b0;
        out_ready = 1'b0;
        xt        = '0;
        clear_mem();
        for (int j = 0; j < H_LEN; j++) begin m_h[j] = 0; m_c[j] = 0; end
        for (int i = 0; i < X_LEN; i++) x_arr[i] = int'($urandom_range(0, 80)) - 40;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ht", ht, '0);
        check("rst_ct", ct, '0);
        check("rst_w_addr", w_addr, '0);

        do_step("zero_w", 1'b1);
        check("zero_w_ht_const", ht, '0);
        check("zero_w_ct_const", ct, '0);
        out_ack();

        set_037();
        do_step("bias", 1'b1);
        check("bias_ht_const", ht, rep10);
        check("bias_ct_const", ct, rep10);
`ifdef LSTM_SAT_FLAG_EN
        check("bias_sat_clear", sat_o, 1'b0);
`endif
        ht_s = ht;
        ct_s = ct;
        changes  = 0;
        busy_err = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ht !== ht_s || ct !== ct_s || out_valid !== 1'b1) changes++;
            if (in_ready !== 1'b0) busy_err++;
        end
        check("hold_stable", changes, 0);
        check("hold_in_ready_low", busy_err, 0);
        out_ack();
        check("in_ready_after_ack", in_ready, 1'b1);

        set_bias(1, 8'h7F);
        do_step("fbias_s1", 1'b1);
        check("fbias_s1_ct_const", ct, rep10);
        out_ack();
        do_step("fbias_s2", 1'b0);
        check("fbias_s2_ct_const", ct, {H_LEN{8'h20}});
        check("fbias_s2_ht_const", ht, rep10);
        out_ack();

        for (int r = 0; r < 6; r++) begin
            bit seq;
            for (int a = 0; a < NW; a++)
                mem[a] = (r < 4) ? DW'(int'($urandom_range(0, 24)) - 12) : DW'($urandom_range(0, 255));
            for (int i = 0; i < X_LEN; i++)
                x_arr[i] = (r < 4) ? int'($urandom_range(0, 80)) - 40 : int'($urandom_range(0, 255)) - 128;
            seq = (r == 0) || ($urandom_range(0, 2) == 0);
            do_step($sformatf("rand%0d", r), seq);
            out_ack();
        end

        set_037();
        start_step(1'b1);
        repeat (100) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_ht", ht, '0);
        check("midrst_ct", ct, '0);
        check("midrst_w_addr", w_addr, '0);
        for (int j = 0; j < H_LEN; j++) begin m_h[j] = 0; m_c[j] = 0; end
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1'b1);
        do_step("rerun", 1'b0);
        check("rerun_ht_const", ht, rep10);
        check("rerun_ct_const", ct, rep10);
        out_ack();

`ifdef LSTM_SAT_FLAG_EN
        clear_mem();
        for (int j = 0; j < H_LEN; j++)
            for (int k = 0; k < 4; k++)
                for (int t = 0; t < X_LEN; t++) mem[(j * 4 + k) * K + t] = 8'sh7F;
        for (int i = 0; i < X_LEN; i++) x_arr[i] = 127;
        do_step("satx", 1'b1);
        check("satx_flag", sat_o, 1'b1);
        out_ack();
        model_step(1'b0);
        start_step(1'b0);
        check("satx_flag_cleared", sat_o, 1'b0);
        finish_step("satx2");
        out_ack();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
